product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
Downstream consumer of the 2x2 array multiplier. Takes its 4-bit products one per beat over a valid/ready handshake and sums a fixed-size group of COUNT products. Presents the group total on a held valid/ready output, with a sticky saturation flag. Forms the accumulate half of the small dot-product datapath.

Parameters:
ACC_W, 8, accumulator and result width in bits; legal range 4 and up.
COUNT, 4, number of products per group; legal range 2 to 255.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
clr  input  1  synchronous abort; discards the group in progress or a pending result.
in_valid  input  1  in_prod is valid this cycle.
in_ready  output  1  block can accept a product this cycle.
in_prod  input  4  unsigned product from the multiplier, range 0..9.
out_valid  output  1  result available.
out_ready  input  1  consumer takes the result this cycle.
out_data  output  ACC_W  unsigned group sum.
out_ovf  output  1  group saturated.

Behaviour:
- Reset (rst high at an edge):
  - state=ACCUM, acc=0, cnt=0, out_valid=0, out_data=0, out_ovf=0.
  - in_ready is 0 during any cycle with rst high.
- Priority: rst > clr > normal operation.
- clr has the same effect as rst on state, acc, cnt, out_valid, out_data and out_ovf. in_ready is 0 during the clr cycle and a beat offered that cycle is not accepted.
- States:
  - ACCUM: in_ready=1 (when not rst/clr), out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: a product is accepted when in_valid and in_ready are both high at an edge. in_prod is ignored at all other times.
- On accept in ACCUM:
  - sum = acc + in_prod, computed at ACC_W+1 bits.
  - If sum > 2^ACC_W-1: acc becomes 2^ACC_W-1 and ovf_int is set. ovf_int is sticky for the rest of the group.
  - Otherwise acc becomes sum.
  - cnt increments.
- Final beat (accept with cnt==COUNT-1):
  - Next state is DONE.
  - out_data takes the saturated sum including this beat; out_ovf takes ovf_int including this beat.
  - out_valid is 1 in the cycle after the final accept. Latency from final accept to out_valid is 1 cycle.
- DONE:
  - out_data and out_ovf are held stable until handshake.
  - On out_valid and out_ready at an edge: next state is ACCUM, acc=0, cnt=0, ovf_int=0, out_valid=0.
  - out_data and out_ovf hold their last values after the handshake; consumers must qualify them with out_valid.
- No output bypass. The minimum period per group is COUNT+1 cycles: COUNT accept cycles plus 1 DONE cycle with out_ready=1.
- in_valid gaps stall the count without altering acc.
- out_ready while in ACCUM is ignored.
- cnt width is ceil(log2(COUNT)). cnt never exceeds COUNT-1 and resets on each group.
- Overflow-free range with ACC_W=8: COUNT up to 28 (9*28=252).

Test Plan:
1. Reset: rst=1 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_data=0, out_ovf=0 during reset; in_ready=1 the cycle after rst falls.
2. Back-to-back group: in_prod 9,4,1,6 on consecutive cycles, out_ready=1 -> out_valid=1 with out_data=20 and out_ovf=0 exactly 1 cycle after the 4th accept; in_ready=0 that cycle; next group's first accept occurs the following cycle.
3. Backpressure: after the group sums to 20, hold out_ready=0 for 5 cycles while driving in_valid=1 with in_prod=7 -> out_data stays 20, in_ready=0, no beats counted; raising out_ready gives one handshake; then 7,7,7,7 yields 28.
4. Bubbles: in_valid pattern 1,0,0,1,0,1,1 with in_prod 3,5,5,2,5,1,1 -> only the beats 3,2,1,1 are accepted; out_data=7.
5. Saturation (ACC_W=4, COUNT=4): in_prod 9,9,0,0 -> out_data=15, out_ovf=1; next group 1,1,1,1 -> out_data=4, out_ovf=0.
6. Abort/reset mid-operation:
   - clr after 2 accepted beats of 9, then 2,2,2,2 -> out_data=8.
   - rst while in DONE -> out_valid=0 the next cycle and no handshake occurs.

Source files
------------

// File: rtl/product_accumulator_if.sv
// Product-stream bus: 4-bit products in, group sums out, plus a synchronous abort.
interface product_accumulator_if #(
    parameter int unsigned ACC_W = 8
);
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_prod;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_ovf;

    // Producer/consumer side: drives products and result acceptance.
    modport master (
        output clr,
        output in_valid,
        output in_prod,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_ovf
    );

    // Accumulator side.
    modport slave (
        input  clr,
        input  in_valid,
        input  in_prod,
        output in_ready,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_ovf
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums groups of COUNT unsigned multiplier products with saturation,
// presenting each group total on a held valid/ready output.
module product_accumulator #(
    parameter int unsigned ACC_W = 8,
    parameter int unsigned COUNT = 4
) (
    input logic                  clk,
    input logic                  rst,
    product_accumulator_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(COUNT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] DONE  = 1'b1;

    logic [0:0]       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf_int;
    logic [ACC_W-1:0] out_data;
    logic             out_ovf;

    logic [ACC_W:0]   sum;
    logic             sat;
    logic [ACC_W-1:0] acc_next;
    logic             ovf_next;
    logic             accept;
    logic             last;

    assign bus.in_ready  = (state == ACCUM) && !rst && !bus.clr;
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = out_data;
    assign bus.out_ovf   = out_ovf;

    // Saturating add of the offered product, and beat bookkeeping.
    always_comb begin
        sum      = {1'b0, acc} + {{(ACC_W - 3){1'b0}}, bus.in_prod};
        sat      = sum[ACC_W];
        acc_next = sat ? '1 : sum[ACC_W-1:0];
        ovf_next = ovf_int | sat;
        accept   = bus.in_valid && bus.in_ready;
        last     = (cnt == LAST_CNT);
    end

    // Group state machine: accumulate COUNT beats, then hold result until taken.
    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            state    <= ACCUM;
            acc      <= '0;
            cnt      <= '0;
            ovf_int  <= 1'b0;
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else if (state == ACCUM) begin
            if (accept) begin
                acc     <= acc_next;
                ovf_int <= ovf_next;
                if (last) begin
                    // cnt is left at COUNT-1 so it never exceeds its range;
                    // the handshake clears it for the next group.
                    state    <= DONE;
                    out_data <= acc_next;
                    out_ovf  <= ovf_next;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end else begin
            if (bus.out_ready) begin
                state   <= ACCUM;
                acc     <= '0;
                cnt     <= '0;
                ovf_int <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench: drives identical stimulus into an 8-bit and a 4-bit
// accumulator (COUNT=4) and checks both against a cycle-level model.
module tb_product_accumulator;
    localparam int unsigned COUNT = 4;

    typedef struct {
        logic [7:0] d8;
        logic       o8;
        logic [3:0] d4;
        logic       o4;
    } result_t;

    logic clk;
    logic rst;

    product_accumulator_if #(.ACC_W(8)) bus8 ();
    product_accumulator_if #(.ACC_W(4)) bus4 ();

    product_accumulator #(.ACC_W(8), .COUNT(COUNT)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    product_accumulator #(.ACC_W(4), .COUNT(COUNT)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    result_t     sb_q[$];
    bit          m_known = 0;
    bit          m_done  = 0;
    int unsigned m_cnt   = 0;
    int unsigned m_acc8  = 0;
    int unsigned m_acc4  = 0;
    bit          m_ovf8  = 0;
    bit          m_ovf4  = 0;
    int unsigned m_last8 = 0;
    int unsigned m_last4 = 0;
    bit          m_lovf8 = 0;
    bit          m_lovf4 = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
    task automatic cycle(input logic v, input logic [3:0] p, input logic ordy,
                         input logic r, input logic c);
        result_t     e;
        int unsigned s;
        bit          exp_ready;
        rst            = r;
        bus8.clr       = c;  bus4.clr       = c;
        bus8.in_valid  = v;  bus4.in_valid  = v;
        bus8.in_prod   = p;  bus4.in_prod   = p;
        bus8.out_ready = ordy; bus4.out_ready = ordy;
        @(negedge clk);
        exp_ready = !r && !c && !m_done;
        if (r) begin
            check_eq("in_ready8_rst", 32'(bus8.in_ready), 32'd0);
            check_eq("in_ready4_rst", 32'(bus4.in_ready), 32'd0);
        end
        if (m_known) begin
            check_eq("in_ready8", 32'(bus8.in_ready), 32'(exp_ready));
            check_eq("in_ready4", 32'(bus4.in_ready), 32'(exp_ready));
            check_eq("out_valid8", 32'(bus8.out_valid), 32'(m_done));
            check_eq("out_valid4", 32'(bus4.out_valid), 32'(m_done));
            check_eq("out_data8", 32'(bus8.out_data), 32'(m_last8));
            check_eq("out_data4", 32'(bus4.out_data), 32'(m_last4));
            check_eq("out_ovf8", 32'(bus8.out_ovf), 32'(m_lovf8));
            check_eq("out_ovf4", 32'(bus4.out_ovf), 32'(m_lovf4));
            if (m_done && ordy && !r && !c && bus8.out_valid) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("sb_data8", 32'(bus8.out_data), 32'(e.d8));
                    check_eq("sb_ovf8", 32'(bus8.out_ovf), 32'(e.o8));
                    check_eq("sb_data4", 32'(bus4.out_data), 32'(e.d4));
                    check_eq("sb_ovf4", 32'(bus4.out_ovf), 32'(e.o4));
                end
            end
        end
        @(posedge clk);
        if (r || c) begin
            m_known = 1;
            m_done  = 0;
            m_cnt   = 0;
            m_acc8  = 0; m_acc4 = 0;
            m_ovf8  = 0; m_ovf4 = 0;
            m_last8 = 0; m_last4 = 0;
            m_lovf8 = 0; m_lovf4 = 0;
            sb_q.delete();
        end else if (m_done) begin
            if (ordy) begin
                m_done = 0;
                m_cnt  = 0;
                m_acc8 = 0; m_acc4 = 0;
                m_ovf8 = 0; m_ovf4 = 0;
            end
        end else if (v) begin
            s = m_acc8 + 32'(p);
            if (s > 255) begin m_acc8 = 255; m_ovf8 = 1; end else m_acc8 = s;
            s = m_acc4 + 32'(p);
            if (s > 15) begin m_acc4 = 15; m_ovf4 = 1; end else m_acc4 = s;
            m_cnt++;
            if (m_cnt == COUNT) begin
                e.d8 = 8'(m_acc8); e.o8 = m_ovf8;
                e.d4 = 4'(m_acc4); e.o4 = m_ovf4;
                sb_q.push_back(e);
                m_last8 = m_acc8; m_lovf8 = m_ovf8;
                m_last4 = m_acc4; m_lovf4 = m_ovf4;
                m_done = 1;
            end
        end
        #1;
    endtask

    task automatic beats(input logic [3:0] p0, input logic [3:0] p1,
                         input logic [3:0] p2, input logic [3:0] p3, input logic ordy);
        cycle(1'b1, p0, ordy, 1'b0, 1'b0);
        cycle(1'b1, p1, ordy, 1'b0, 1'b0);
        cycle(1'b1, p2, ordy, 1'b0, 1'b0);
        cycle(1'b1, p3, ordy, 1'b0, 1'b0);
    endtask

    logic [6:0] bub_v;
    logic [3:0] bub_p[7];

    initial begin
        // Reset with in_valid held high
        cycle(1'b1, 4'd5, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 4'd5, 1'b0, 1'b1, 1'b0);

        // Back-to-back groups, then backpressure with beats offered
        beats(4'd9, 4'd4, 4'd1, 4'd6, 1'b1);
        cycle(1'b1, 4'd8, 1'b1, 1'b0, 1'b0);
        beats(4'd9, 4'd4, 4'd1, 4'd6, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
        beats(4'd7, 4'd7, 4'd7, 4'd7, 1'b1);
        cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);

        // Bubbles: only 3,2,1,1 are taken
        bub_v = 7'b1101001;
        bub_p = '{4'd3, 4'd5, 4'd5, 4'd2, 4'd5, 4'd1, 4'd1};
        for (int i = 0; i < 7; i++) cycle(bub_v[i], bub_p[i], 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);

        // Saturation on the narrow instance, then a clean group
        beats(4'd9, 4'd9, 4'd0, 4'd0, 1'b1);
        cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        beats(4'd1, 4'd1, 4'd1, 4'd1, 1'b1);
        cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        beats(4'd9, 4'd9, 4'd9, 4'd9, 1'b1);
        cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);

        // Abort mid-group, then a full group
        cycle(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'd9, 1'b0, 1'b0, 1'b1);
        beats(4'd2, 4'd2, 4'd2, 4'd2, 1'b0);
        cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);

        // Reset while a result is pending: no handshake
        beats(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);

        // Clear while a result is pending
        beats(4'd5, 4'd5, 4'd5, 4'd5, 1'b0);
        cycle(1'b1, 4'd3, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);

        // Random traffic with occasional aborts
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 9)),
                  1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 40) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
